// File: rtl/fifo_v3_sync.sv
// -----------------------------------------------------------------------------
// fifo_v3_sync
//   Synchronous single-clock FIFO built on a circular buffer. It supports an
//   optional fall-through mode, a synchronous flush and an occupancy count.
//   The payload can be any type, including packed structs.
//
// Parameters
//   FALL_THROUGH : 1 = an empty FIFO forwards data_i to data_o in the same cycle
//   DATA_WIDTH   : payload width when dtype is left at its default
//   DEPTH        : number of entries (>= 1)
//   dtype        : payload type
//   ADDR_DEPTH   : pointer width (derived, do not override)
//
// Ports
//   clk_i      in   clock
//   rst_ni     in   asynchronous active-low reset
//   flush_i    in   synchronous clear of pointers and count
//   testmode_i in   clock-gating bypass, no functional effect here
//   full_o     out  FIFO holds DEPTH entries
//   empty_o    out  no data available
//   usage_o    out  entry count, low ADDR_DEPTH bits (reads 0 when full and
//                   DEPTH is a power of two; use full_o to tell these apart)
//   data_i     in   push data
//   push_i     in   push request
//   data_o     out  head-of-queue data
//   pop_i      in   pop request
// -----------------------------------------------------------------------------
module fifo_v3_sync #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  if (DEPTH == 0) begin : g_depth_check
    $error("fifo_v3_sync: DEPTH must be at least 1");
  end

  localparam int unsigned MemDepth = (DEPTH > 0) ? DEPTH : 1;
  localparam logic [ADDR_DEPTH-1:0] LastPtr  = ADDR_DEPTH'(MemDepth - 1);
  localparam logic [ADDR_DEPTH:0]   FullCnt  = (ADDR_DEPTH + 1)'(MemDepth);
  localparam logic [ADDR_DEPTH:0]   CntOne   = (ADDR_DEPTH + 1)'(1);

  logic [ADDR_DEPTH-1:0] read_ptr_q,   read_ptr_d;
  logic [ADDR_DEPTH-1:0] write_ptr_q,  write_ptr_d;
  logic [ADDR_DEPTH:0]   status_cnt_q, status_cnt_d;
  dtype                  mem_q [MemDepth];
  logic                  mem_we;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  bypass;

  // Clock gating is not used inside this block, so the test-mode input is
  // intentionally left unconsumed.
  logic unused_testmode;
  assign unused_testmode = testmode_i;

  // Status outputs come straight from registered state. The only exception is
  // the fall-through path, where an incoming push makes the FIFO non-empty.
  assign full_o  = (status_cnt_q == FullCnt);
  assign empty_o = (status_cnt_q == '0) && !(FALL_THROUGH && push_i);
  assign usage_o = status_cnt_q[ADDR_DEPTH-1:0];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  // In fall-through mode, a push and pop to an empty FIFO hand the word
  // straight through without touching storage.
  assign bypass  = FALL_THROUGH && (status_cnt_q == '0) && push_i && pop_i;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    read_ptr_d   = read_ptr_q;
    write_ptr_d  = write_ptr_q;
    status_cnt_d = status_cnt_q;
    mem_we       = 1'b0;
    data_o       = mem_q[read_ptr_q];

    if (FALL_THROUGH && (status_cnt_q == '0) && push_i) begin
      data_o = data_i;
    end

    if (push_ok) begin
      mem_we      = 1'b1;
      write_ptr_d = (write_ptr_q == LastPtr) ? '0 : write_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      read_ptr_d = (read_ptr_q == LastPtr) ? '0 : read_ptr_q + 1'b1;
    end

    if (push_ok && !pop_ok) begin
      status_cnt_d = status_cnt_q + CntOne;
    end else if (pop_ok && !push_ok) begin
      status_cnt_d = status_cnt_q - CntOne;
    end

    if (bypass) begin
      read_ptr_d   = read_ptr_q;
      write_ptr_d  = write_ptr_q;
      status_cnt_d = status_cnt_q;
      mem_we       = 1'b0;
    end

    // A flush wins over any push or pop in the same cycle. Storage is left
    // untouched because the cleared pointers make it unreachable.
    if (flush_i) begin
      read_ptr_d   = '0;
      write_ptr_d  = '0;
      status_cnt_d = '0;
      mem_we       = 1'b0;
    end
  end

  // NOTE: registers are updated with non-blocking assignments, so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_ptr_q   <= '0;
      write_ptr_q  <= '0;
      status_cnt_q <= '0;
    end else begin
      read_ptr_q   <= read_ptr_d;
      write_ptr_q  <= write_ptr_d;
      status_cnt_q <= status_cnt_d;
    end
  end

  // NOTE: storage is cleared on reset on purpose, so data_o reads 0 out of
  // reset. This prevents the array from mapping to RAM macros without reset,
  // which is acceptable at the small depths this FIFO is used at.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MemDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[write_ptr_q] <= data_i;
    end
  end

  // The producer and consumer are expected to honour full_o and empty_o.
  // These checks flag violations. The request is still dropped silently in
  // hardware, so the checks only warn.
  push_while_full : assert property (
    @(posedge clk_i) disable iff (!rst_ni) (push_i && !flush_i) |-> !full_o)
    else $warning("fifo_v3_sync: push while full, request dropped");

  pop_while_empty : assert property (
    @(posedge clk_i) disable iff (!rst_ni) (pop_i && !flush_i) |-> !empty_o)
    else $warning("fifo_v3_sync: pop while empty, request dropped");

endmodule

// File: tb/tb_fifo_v3_sync.sv
// -----------------------------------------------------------------------------
// tb_fifo_v3_sync
//   Directed bench for fifo_v3_sync. It uses three instances:
//     u_d2 : DEPTH=2, FALL_THROUGH=0 (basic fill/drain, full/drop, flush, reset)
//     u_d3 : DEPTH=3, FALL_THROUGH=0 (ordering across non-power-of-two wrap)
//     u_ft : DEPTH=2, FALL_THROUGH=1 (same-cycle bypass)
//   Inputs change 1 time unit after a rising edge. Outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_fifo_v3_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DEPTH=2, no fall-through
  logic       a_flush = 0, a_push = 0, a_pop = 0, a_full, a_empty;
  logic       a_usage;
  logic [7:0] a_din = '0, a_dout;

  // DEPTH=3, no fall-through
  logic       b_flush = 0, b_push = 0, b_pop = 0, b_full, b_empty;
  logic [1:0] b_usage;
  logic [7:0] b_din = '0, b_dout;

  // DEPTH=2, fall-through
  logic       f_flush = 0, f_push = 0, f_pop = 0, f_full, f_empty;
  logic       f_usage;
  logic [7:0] f_din = '0, f_dout;

  fifo_v3_sync #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(2)) u_d2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .testmode_i(1'b0),
    .full_o(a_full), .empty_o(a_empty), .usage_o(a_usage),
    .data_i(a_din), .push_i(a_push), .data_o(a_dout), .pop_i(a_pop));

  fifo_v3_sync #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .testmode_i(1'b0),
    .full_o(b_full), .empty_o(b_empty), .usage_o(b_usage),
    .data_i(b_din), .push_i(b_push), .data_o(b_dout), .pop_i(b_pop));

  fifo_v3_sync #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(2)) u_ft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f_flush), .testmode_i(1'b0),
    .full_o(f_full), .empty_o(f_empty), .usage_o(f_usage),
    .data_i(f_din), .push_i(f_push), .data_o(f_dout), .pop_i(f_pop));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input logic push, input logic pop, input logic [7:0] din);
    a_push = push;
    a_pop  = pop;
    a_din  = din;
  endtask

  logic [7:0] model_q[$];
  int         sent;
  int         popped;
  logic       b_push_ok;
  logic       b_pop_ok;

  initial begin
    // ---------------- reset ----------------
    #2 rst_n = 1'b0;
    #2;
    check("rst_empty", a_empty, 1);
    check("rst_full",  a_full,  0);
    check("rst_usage", a_usage, 0);
    check("rst_data",  a_dout,  0);
    check("rst_d3_empty", b_empty, 1);
    check("rst_ft_empty", f_empty, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---------------- fill A, B; drop C; drain ----------------
    a_set(1, 0, 8'hA1);
    step();
    check("fill1_usage", a_usage, 1);
    check("fill1_data",  a_dout,  8'hA1);
    check("fill1_empty", a_empty, 0);
    check("fill1_full",  a_full,  0);
    a_set(1, 0, 8'hB2);
    step();
    check("fill2_full",  a_full,  1);
    check("fill2_usage", a_usage, 0);
    check("fill2_data",  a_dout,  8'hA1);
    a_set(1, 0, 8'hC3);
    step();
    check("drop_full", a_full, 1);
    check("drop_data", a_dout, 8'hA1);
    a_set(0, 1, 8'h00);
    step();
    check("pop1_data",  a_dout,  8'hB2);
    check("pop1_usage", a_usage, 1);
    check("pop1_full",  a_full,  0);
    step();
    check("pop2_empty", a_empty, 1);
    check("pop2_usage", a_usage, 0);

    // ---------------- simultaneous push/pop ----------------
    a_set(1, 0, 8'hA1);
    step();
    a_set(1, 1, 8'hB2);
    step();
    check("pp1_usage", a_usage, 1);
    check("pp1_data",  a_dout,  8'hB2);
    a_set(1, 0, 8'hC3);
    step();
    check("pp_fill_full", a_full, 1);
    a_set(1, 1, 8'hD4);
    step();
    check("ppfull_full",  a_full,  0);
    check("ppfull_usage", a_usage, 1);
    check("ppfull_data",  a_dout,  8'hC3);
    a_set(0, 1, 8'h00);
    step();
    check("pp_drain_empty", a_empty, 1);
    a_set(0, 0, 8'h00);

    // ---------------- flush overrides push ----------------
    a_set(1, 0, 8'h11);
    step();
    a_set(1, 0, 8'h22);
    step();
    check("flush_pre_full", a_full, 1);
    a_flush = 1'b1;
    a_set(1, 0, 8'h33);
    step();
    a_flush = 1'b0;
    a_set(0, 0, 8'h00);
    check("flush_empty", a_empty, 1);
    check("flush_usage", a_usage, 0);
    check("flush_full",  a_full,  0);

    // ---------------- async reset mid-stream ----------------
    a_set(1, 0, 8'h5C);
    step();
    a_set(0, 0, 8'h00);
    check("arst_pre_usage", a_usage, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_empty", a_empty, 1);
    check("arst_usage", a_usage, 0);
    check("arst_data",  a_dout,  0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---------------- DEPTH=3 ordering across wrap ----------------
    sent   = 0;
    popped = 0;
    for (int c = 0; c < 60 && popped < 10; c++) begin
      b_push = (sent < 10) && !b_full;
      b_din  = 8'h40 + 8'(sent);
      b_pop  = (c >= 3) && (c % 2 == 1);
      b_push_ok = b_push && (model_q.size() < 3);
      b_pop_ok  = b_pop && (model_q.size() > 0);
      if (b_pop_ok) check("d3_pop_data", b_dout, model_q[0]);
      step();
      if (b_pop_ok) begin
        void'(model_q.pop_front());
        popped++;
      end
      if (b_push_ok) begin
        model_q.push_back(b_din);
        sent++;
      end
      check("d3_usage", b_usage, model_q.size());
      check("d3_full",  b_full,  model_q.size() == 3);
      check("d3_empty", b_empty, model_q.size() == 0);
    end
    b_push = 0;
    b_pop  = 0;
    check("d3_all_popped", popped, 10);

    // ---------------- fall-through ----------------
    f_push = 1;
    f_pop  = 1;
    f_din  = 8'h5A;
    #1;
    check("ft_bypass_data",  f_dout,  8'h5A);
    check("ft_bypass_empty", f_empty, 0);
    step();
    f_push = 0;
    f_pop  = 0;
    #1;
    check("ft_after_empty", f_empty, 1);
    check("ft_after_usage", f_usage, 0);
    f_push = 1;
    f_din  = 8'h66;
    #1;
    check("ft_push_comb_data", f_dout, 8'h66);
    step();
    f_push = 0;
    #1;
    check("ft_store_usage", f_usage, 1);
    check("ft_store_data",  f_dout,  8'h66);
    f_pop = 1;
    step();
    f_pop = 0;
    #1;
    check("ft_drain_empty", f_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run cannot hang.
  initial begin
    #50000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
